// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: CPU clock-enable generator with divided free-run and debounced single-step.
module clk_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DIV_WIDTH       = 21,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_step,
    input  logic                 mode_run,
    input  logic [4:0]           div_sel,
    input  logic                 halt,
    output logic                 cpu_ce,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] step_count
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {ST_STEP, ST_RUN, ST_HALTED} state_t;

    state_t               state_q, state_d;
    logic [1:0]           btn_sync_q, run_sync_q;
    logic [DBW-1:0]       db_cnt_q, db_cnt_d;
    logic                 btn_db_q, btn_db_d, btn_dd_q;
    logic [DIV_WIDTH-1:0] div_q, div_d, tc;
    logic [4:0]           sel_q, ds;
    logic                 ce_q, ce_d;
    logic [CNT_WIDTH-1:0] step_count_q;
    logic                 btn_s, run_s, step_req, sel_chg, tick, db_hit;

    always_comb begin
        btn_s    = btn_sync_q[1];
        run_s    = run_sync_q[1];
        step_req = btn_db_q & ~btn_dd_q;
        db_hit   = db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1);
        db_cnt_d = (btn_s == btn_db_q || db_hit) ? '0 : db_cnt_q + DBW'(1);
        btn_db_d = (btn_s != btn_db_q && db_hit) ? btn_s : btn_db_q;
        ds       = (div_sel > 5'(DIV_WIDTH - 1)) ? 5'(DIV_WIDTH - 1) : div_sel;
        tc       = (DIV_WIDTH'(1) << ds) - DIV_WIDTH'(1);
        // a rate change restarts the divider, so no tick is taken from the stale count
        sel_chg  = div_sel != sel_q;
        tick     = state_q == ST_RUN && !sel_chg && div_q == tc;
        div_d    = (state_q != ST_RUN || sel_chg || div_q == tc) ? '0 : div_q + DIV_WIDTH'(1);
        ce_d     = (state_q == ST_STEP && step_req) || (tick && !halt);
        state_d  = state_q;
        case (state_q)
            ST_STEP:   state_d = run_s ? ST_RUN : ST_STEP;
            ST_RUN:    state_d = !run_s ? ST_STEP : halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = !run_s ? ST_STEP : ST_HALTED;
            default:   state_d = ST_STEP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_STEP;
            btn_sync_q   <= '0;
            run_sync_q   <= '0;
            db_cnt_q     <= '0;
            btn_db_q     <= 1'b0;
            btn_dd_q     <= 1'b0;
            div_q        <= '0;
            sel_q        <= '0;
            ce_q         <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            btn_sync_q   <= {btn_sync_q[0], btn_step};
            run_sync_q   <= {run_sync_q[0], mode_run};
            db_cnt_q     <= db_cnt_d;
            btn_db_q     <= btn_db_d;
            btn_dd_q     <= btn_db_q;
            div_q        <= div_d;
            sel_q        <= div_sel;
            ce_q         <= ce_d;
            step_count_q <= step_count_q + CNT_WIDTH'(ce_q);
        end
    end

    assign cpu_ce     = ce_q;
    assign running    = state_q == ST_RUN;
    assign halted     = state_q == ST_HALTED;
    assign step_count = step_count_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: rate table, directed step/halt/reset sequences and a random run against a reference model.
module tb_clk_step_ctrl;
    localparam int D = 4, DW = 4, CW = 16;

    logic          clk = 1'b0, rst = 1'b0, btn_step = 1'b0, mode_run = 1'b0, halt = 1'b0;
    logic [4:0]    div_sel = 5'd0;
    logic          cpu_ce, running, halted;
    logic [CW-1:0] step_count;
    int            checks = 0, errors = 0;

    clk_step_ctrl #(.DEBOUNCE_CYCLES(D), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .mode_run(mode_run), .div_sel(div_sel),
        .halt(halt), .cpu_ce(cpu_ce), .running(running), .halted(halted), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // model: st 0=STEP 1=RUN 2=HALTED; age = RUN cycles since the rate phase last restarted
    logic          r1, bs, db, dd, m1, rs, ce;
    int            mis, st, age;
    logic [4:0]    sel;
    logic [CW-1:0] cnt;

    task automatic mdl_reset();
        r1 = 0; bs = 0; db = 0; dd = 0; m1 = 0; rs = 0; ce = 0;
        mis = 0; st = 0; age = 0; sel = 0; cnt = 0;
    endtask

    task automatic mdl();
        int p, nst;
        bit t, nce;
        if (!rst) begin
            mdl_reset();
            return;
        end
        p   = 1 << ((div_sel > DW - 1) ? DW - 1 : int'(div_sel));
        t   = (st == 1) && (div_sel == sel) && (age % p == p - 1);
        nce = (st == 0 && db && !dd) || (t && !halt);
        nst = (st == 0) ? (rs ? 1 : 0) : !rs ? 0 : (st == 1 && halt) ? 2 : st;
        age = (st == 1 && div_sel == sel) ? age + 1 : 0;
        cnt = cnt + CW'(ce);
        ce  = nce;
        st  = nst;
        sel = div_sel;
        dd  = db;
        if (bs != db) begin
            mis++;
            if (mis == D) begin
                db  = bs;
                mis = 0;
            end
        end else mis = 0;
        bs = r1; r1 = btn_step;
        rs = m1; m1 = mode_run;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        mdl();
        #1;
        chk("cpu_ce", cpu_ce, ce);
        chk("running", running, st == 1);
        chk("halted", halted, st == 2);
        chk("step_count", step_count, cnt);
    endtask

    task automatic press(input int hold, output int first, output int n);
        btn_step = 1; first = -1; n = 0;
        for (int k = 1; k <= hold; k++) begin
            cyc();
            if (cpu_ce) begin
                n++;
                if (first < 0) first = k;
            end
        end
        btn_step = 0;
        repeat (12) begin
            cyc();
            if (cpu_ce) n++;
        end
    endtask

    task automatic assert_rst();
        rst = 0;
        mdl_reset();
        #1;
        chk("rst_ce", cpu_ce, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", step_count, 0);
    endtask

    typedef struct { logic [4:0] sel; int per; } vec_t;
    vec_t vt[6];

    initial begin
        int first, n, last, per;
        vt[0] = '{5'd0, 1}; vt[1] = '{5'd1, 2}; vt[2] = '{5'd2, 4};
        vt[3] = '{5'd3, 8}; vt[4] = '{5'd4, 8}; vt[5] = '{5'd31, 8};
        mdl_reset();
        repeat (2) cyc();
        assert_rst();
        rst = 1;
        // short glitch is rejected
        btn_step = 1;
        repeat (3) cyc();
        btn_step = 0;
        n = 0;
        repeat (15) begin
            cyc();
            n += int'(cpu_ce);
        end
        chk("glitch_pulses", n, 0);
        chk("glitch_count", step_count, 0);
        // held press gives one pulse after edge D+3
        press(20, first, n);
        chk("step_latency", first, D + 3);
        chk("step_pulses", n, 1);
        chk("step_count_one", step_count, 1);
        // free-run window with div_sel=2
        mode_run = 1; div_sel = 2; n = 0;
        repeat (40) begin
            cyc();
            n += int'(cpu_ce);
        end
        chk("run_window", (n >= 9 && n <= 11), 1);
        // every-cycle run, then halt, press in HALTED, back to STEP and step-over
        div_sel = 0;
        repeat (8) cyc();
        n = 0;
        repeat (5) begin
            cyc();
            n += int'(cpu_ce);
        end
        chk("ce_every_cycle", n, 5);
        halt = 1;
        cyc();
        chk("halt_ce", cpu_ce, 0);
        chk("halt_state", halted, 1);
        press(12, first, n);
        chk("halted_press", n, 0);
        mode_run = 0;
        cyc();
        cyc();
        chk("halted_sync", halted, 1);
        cyc();
        chk("back_to_step", {running, halted}, 0);
        press(12, first, n);
        chk("step_over", n, 1);
        halt = 0;
        // free-run period table
        foreach (vt[i]) begin
            div_sel = vt[i].sel; mode_run = 1; last = -1; per = 0;
            for (int c = 0; c < 40; c++) begin
                cyc();
                if (cpu_ce) begin
                    if (last >= 0 && per == 0) per = c - last;
                    last = c;
                end
            end
            chk($sformatf("period_sel%0d", vt[i].sel), per, vt[i].per);
            mode_run = 0;
            repeat (4) cyc();
        end
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 39) == 0) mode_run = ~mode_run;
            if ($urandom_range(0, 29) == 0) div_sel = 5'($urandom_range(0, 5));
            halt = ($urandom_range(0, 9) == 0);
            cyc();
        end
        btn_step = 0; halt = 0; mode_run = 0;
        repeat (12) cyc();
        // step_count wrap
        mode_run = 1; div_sel = 0;
        for (int i = 0; i < 70000 && cnt != 16'hFFFF; i++) cyc();
        chk("preload", step_count, 16'hFFFF);
        cyc();
        chk("wrap", step_count, 0);
        // reset during RUN
        repeat (3) cyc();
        assert_rst();
        mode_run = 0;
        cyc();
        rst = 1;
        repeat (4) cyc();
        // reset mid-debounce, release with the button held
        btn_step = 1;
        repeat (4) cyc();
        assert_rst();
        cyc();
        rst = 1;
        press(20, first, n);
        chk("rst_latency", first, D + 3);
        chk("rst_pulses", n, 1);
        chk("rst_count_one", step_count, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
